// File: rtl/unidade_busca_pkg.sv
// Shared CPU definitions: opcodes, instruction field positions and fetch FSM states.
package pacote_cpu;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_LDA = 4'b0010;
    localparam logic [3:0] OP_STA = 4'b0011;
    localparam logic [3:0] OP_LDB = 4'b0100;
    localparam logic [3:0] OP_STB = 4'b0101;
    localparam logic [3:0] OP_LDC = 4'b0110;
    localparam logic [3:0] OP_JMP = 4'b0111;
    localparam logic [3:0] OP_AND = 4'b1000;
    localparam logic [3:0] OP_OR  = 4'b1001;
    localparam logic [3:0] OP_BEQ = 4'b1010;

    localparam int unsigned OPC_MSB = 7;
    localparam int unsigned OPC_LSB = 4;
    localparam int unsigned OPR_MSB = 3;
    localparam int unsigned OPR_LSB = 0;

    typedef enum logic [1:0] {
        StBusca      = 2'd0,
        StDecodifica = 2'd1,
        StExecuta    = 2'd2,
        StParado     = 2'd3
    } estado_t;

endpackage

// File: rtl/unidade_busca_if.sv
// ROM bus, datapath handshake, datapath flags and status of the fetch unit.
interface unidade_busca_if;

    logic       habilita;
    logic [7:0] endereco_rom;
    logic [7:0] instrucao_rom;
    logic [3:0] opcode;
    logic [3:0] operando;
    logic       exec_valido;
    logic       exec_pronto;
    logic       flag_a_zero;
    logic       flag_b_zero;
    logic       flag_a_igual_b;
    logic [7:0] pc;
    logic       parado;

    // Fetch unit side
    modport master (
        input  habilita, instrucao_rom, exec_pronto,
        input  flag_a_zero, flag_b_zero, flag_a_igual_b,
        output endereco_rom, opcode, operando, exec_valido, pc, parado
    );

    // ROM / datapath / control side
    modport slave (
        output habilita, instrucao_rom, exec_pronto,
        output flag_a_zero, flag_b_zero, flag_a_igual_b,
        input  endereco_rom, opcode, operando, exec_valido, pc, parado
    );

endinterface

// File: rtl/unidade_busca_avaliador_desvio.sv
// Classifies an opcode as branch / undefined and resolves the branch condition.
module avaliador_desvio
    import pacote_cpu::*;
(
    input  logic [3:0] i_opcode,
    input  logic       i_flag_a_zero,
    input  logic       i_flag_b_zero,
    input  logic       i_flag_a_igual_b,
    output logic       o_eh_desvio,
    output logic       o_desvio_tomado,
    output logic       o_eh_invalido
);

    // Opcode classification; 1011-1111 fall through to undefined
    always_comb begin
        o_eh_desvio     = 1'b0;
        o_desvio_tomado = 1'b0;
        o_eh_invalido   = 1'b0;
        case (i_opcode)
            OP_JMP: begin
                o_eh_desvio     = 1'b1;
                o_desvio_tomado = i_flag_a_zero && i_flag_b_zero;
            end
            OP_BEQ: begin
                o_eh_desvio     = 1'b1;
                o_desvio_tomado = i_flag_a_igual_b;
            end
            OP_ADD, OP_SUB, OP_LDA, OP_STA, OP_LDB,
            OP_STB, OP_LDC, OP_AND, OP_OR: begin
                o_eh_desvio = 1'b0;
            end
            default: o_eh_invalido = 1'b1;
        endcase
    end

endmodule

// File: rtl/unidade_busca.sv
// Fetch/decode controller: drives ROM address from pc, latches IR, resolves
// branches locally and offers the remaining instructions to the datapath.
module unidade_busca
    import pacote_cpu::*;
#(
    parameter logic [7:0] PC_RESET = 8'h00
) (
    input  logic            clk,
    input  logic            rst_n,
    unidade_busca_if.master bus
);

    estado_t    r_estado;
    logic [7:0] r_pc;
    logic [7:0] r_ir;
    logic       r_exec_valido;
    logic       r_parado;

    logic       w_eh_desvio;
    logic       w_desvio_tomado;
    logic       w_eh_invalido;

    avaliador_desvio u_avaliador_desvio (
        .i_opcode         (r_ir[OPC_MSB:OPC_LSB]),
        .i_flag_a_zero    (bus.flag_a_zero),
        .i_flag_b_zero    (bus.flag_b_zero),
        .i_flag_a_igual_b (bus.flag_a_igual_b),
        .o_eh_desvio      (w_eh_desvio),
        .o_desvio_tomado  (w_desvio_tomado),
        .o_eh_invalido    (w_eh_invalido)
    );

    // Fetch FSM with pc, IR and registered status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_estado      <= StBusca;
            r_pc          <= PC_RESET;
            r_ir          <= 8'h00;
            r_exec_valido <= 1'b0;
            r_parado      <= 1'b0;
        end else begin
            case (r_estado)
                StBusca: begin
                    if (bus.habilita) begin
                        r_ir     <= bus.instrucao_rom;
                        r_estado <= StDecodifica;
                    end
                end
                StDecodifica: begin
                    if (w_eh_invalido) begin
                        // pc is left pointing at the offending instruction
                        r_parado <= 1'b1;
                        r_estado <= StParado;
                    end else if (w_eh_desvio) begin
                        r_pc     <= w_desvio_tomado ? {4'b0000, r_ir[OPR_MSB:OPR_LSB]}
                                                    : r_pc + 8'd1;
                        r_estado <= StBusca;
                    end else begin
                        r_exec_valido <= 1'b1;
                        r_estado      <= StExecuta;
                    end
                end
                StExecuta: begin
                    if (bus.exec_pronto) begin
                        r_pc          <= r_pc + 8'd1;
                        r_exec_valido <= 1'b0;
                        r_estado      <= StBusca;
                    end
                end
                StParado: begin
                    r_estado <= StParado;
                end
                default: r_estado <= StParado;
            endcase
        end
    end

    assign bus.endereco_rom = r_pc;
    assign bus.pc           = r_pc;
    assign bus.opcode       = r_ir[OPC_MSB:OPC_LSB];
    assign bus.operando     = r_ir[OPR_MSB:OPR_LSB];
    assign bus.exec_valido  = r_exec_valido;
    assign bus.parado       = r_parado;

endmodule
